pixel_row_packer: RTL and testbench

//  Input stage of the CNN. Converts a pixel-serial byte stream into packed W-pixel image rows.
//  Its output feeds the first 3-line buffer through row_data / row_valid.

---
 rtl/pixel_row_packer.sv | 94 +++++++++
 tb/tb_pixel_row_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_row_packer.sv
// Packs a pixel-serial byte stream into W-pixel rows held in two ping-pong buffers,
// tracking the row position within an H-row frame and flagging misplaced start-of-frame.
module pixel_row_packer #(
    parameter int W         = 24,
    parameter int H         = 24,
    parameter int DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_BITS-1:0]     s_data,
    input  logic                     s_sof,
    output logic [W*DATA_BITS-1:0]   row_data,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [$clog2(H)-1:0]     row_idx,
    output logic                     row_last,
    output logic                     frame_done,
    output logic                     sof_err
);

    localparam int COL_W = $clog2(W);
    localparam int IDX_W = $clog2(H);
    localparam int ROW_W = W * DATA_BITS;

    logic [COL_W-1:0] col;
    logic [IDX_W-1:0] row_in;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       buf_full;
    logic [ROW_W-1:0] buf_data [2];
    logic [IDX_W-1:0] buf_idx  [2];

    logic             accept;
    logic             xfer;
    logic             restart;
    logic             row_done;
    logic [COL_W-1:0] wr_col;
    logic [IDX_W-1:0] cur_row;

    assign s_ready    = ~buf_full[wr_ptr];
    assign row_valid  = buf_full[rd_ptr];
    assign row_data   = buf_data[rd_ptr];
    assign row_idx    = buf_idx[rd_ptr];
    assign row_last   = row_valid & (row_idx == IDX_W'(H - 1));
    assign frame_done = xfer & row_last;

    assign accept   = s_valid & s_ready;
    assign xfer     = row_valid & row_ready;
    // A start-of-frame anywhere but col0/row0 abandons the partial row and restarts the frame.
    assign restart  = accept & s_sof & ((col != '0) | (row_in != '0));
    assign wr_col   = restart ? '0 : col;
    assign cur_row  = restart ? '0 : row_in;
    assign row_done = accept & (wr_col == COL_W'(W - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col         <= '0;
            row_in      <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            buf_full    <= 2'b00;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_idx[0]  <= '0;
            buf_idx[1]  <= '0;
            sof_err     <= 1'b0;
        end else begin
            if (accept) begin
                buf_data[wr_ptr][wr_col*DATA_BITS +: DATA_BITS] <= s_data;
                if (row_done) begin
                    buf_full[wr_ptr] <= 1'b1;
                    buf_idx[wr_ptr]  <= cur_row;
                    col              <= '0;
                    wr_ptr           <= ~wr_ptr;
                    row_in           <= (cur_row == IDX_W'(H - 1)) ? '0 : cur_row + 1'b1;
                end else begin
                    col    <= wr_col + 1'b1;
                    row_in <= cur_row;
                end
            end
            if (restart) begin
                sof_err <= 1'b1;
            end
            // Fill always targets an empty buffer and transfer a full one, so the bits never collide.
            if (xfer) begin
                buf_full[rd_ptr] <= 1'b0;
                rd_ptr           <= ~rd_ptr;
            end
        end
    end

endmodule

// File: tb/tb_pixel_row_packer.sv
// Self-checking bench for pixel_row_packer: reference row model with a scoreboard queue,
// a backpressure vector table and directed multi-cycle sequences.
module tb_pixel_row_packer;

    localparam int W   = 24;
    localparam int H   = 24;
    localparam int DB  = 8;
    localparam int RW  = W * DB;
    localparam int IW  = $clog2(H);

    logic          clk = 1'b0;
    logic          resetn;
    logic          s_valid;
    logic          s_ready;
    logic [DB-1:0] s_data;
    logic          s_sof;
    logic [RW-1:0] row_data;
    logic          row_valid;
    logic          row_ready;
    logic [IW-1:0] row_idx;
    logic          row_last;
    logic          frame_done;
    logic          sof_err;

    pixel_row_packer #(.W(W), .H(H), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .row_data   (row_data),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_idx    (row_idx),
        .row_last   (row_last),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RW-1:0] data;
        logic [IW-1:0] idx;
    } row_t;

    typedef struct {
        int   n_px;
        int   exp_acc;
        logic exp_ready;
        logic exp_valid;
    } bp_vec_t;

    row_t exp_q[$];
    int   n_tests = 0;
    int   n_fails = 0;

    int            m_col;
    int            m_row;
    logic [RW-1:0] m_buf;
    int            rows_out;
    int            fd_cnt;
    int            acc_cnt;
    logic [IW-1:0] last_idx;
    logic [RW-1:0] last_data;
    bit            rnd_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: transfers are popped before the same cycle's accepted pixel can push a row.
    always @(negedge clk) begin
        if (resetn) begin
            if (row_valid && row_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_row", 1, 0);
                end else begin
                    row_t e;
                    e = exp_q.pop_front();
                    check("row_data", row_data, e.data);
                    check("row_idx", row_idx, e.idx);
                    check("row_last", row_last, (e.idx == IW'(H - 1)));
                    check("frame_done", frame_done, (e.idx == IW'(H - 1)));
                    rows_out++;
                    fd_cnt += int'(frame_done);
                    last_idx  = row_idx;
                    last_data = row_data;
                end
            end else if (frame_done) begin
                check("frame_done_idle", frame_done, 0);
            end
            if (s_valid && s_ready) begin
                acc_cnt++;
                if (s_sof && !(m_col == 0 && m_row == 0)) begin
                    m_col = 0;
                    m_row = 0;
                end
                m_buf[m_col*DB +: DB] = s_data;
                if (m_col == W - 1) begin
                    exp_q.push_back('{data: m_buf, idx: IW'(m_row)});
                    m_col = 0;
                    m_row = (m_row == H - 1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1 row_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tb_reset(input bit chk);
        @(posedge clk);
        #1 resetn = 1'b0;
        exp_q.delete();
        m_col = 0; m_row = 0; m_buf = '0;
        rows_out = 0; fd_cnt = 0; acc_cnt = 0;
        last_idx = '0; last_data = '0;
        repeat (2) @(negedge clk);
        if (chk) begin
            check("rst_row_valid", row_valid, 0);
            check("rst_row_data", row_data, 0);
            check("rst_row_idx", row_idx, 0);
            check("rst_row_last", row_last, 0);
            check("rst_frame_done", frame_done, 0);
            check("rst_sof_err", sof_err, 0);
            check("rst_s_ready", s_ready, 1);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic send_px(input logic [DB-1:0] d, input bit sof, input int budget, output bit ok);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        ok      = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic stream(input int n, input int base);
        bit ok;
        for (int i = 0; i < n; i++) begin
            send_px(DB'(base + i * 7), 1'b0, 200, ok);
            if (!ok) check("stream_timeout", 0, 1);
        end
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bp_vec_t       bp_tbl[6];
        logic [RW-1:0] row0;
        bit            ok;
        int            acc;

        bp_tbl[0] = '{n_px: 1,  exp_acc: 1,  exp_ready: 1'b1, exp_valid: 1'b0};
        bp_tbl[1] = '{n_px: 23, exp_acc: 23, exp_ready: 1'b1, exp_valid: 1'b0};
        bp_tbl[2] = '{n_px: 24, exp_acc: 24, exp_ready: 1'b1, exp_valid: 1'b1};
        bp_tbl[3] = '{n_px: 47, exp_acc: 47, exp_ready: 1'b1, exp_valid: 1'b1};
        bp_tbl[4] = '{n_px: 48, exp_acc: 48, exp_ready: 1'b0, exp_valid: 1'b1};
        bp_tbl[5] = '{n_px: 50, exp_acc: 48, exp_ready: 1'b0, exp_valid: 1'b1};

        for (int k = 0; k < W; k++) row0[k*DB +: DB] = DB'(k);

        resetn = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; row_ready = 1'b0;
        tb_reset(1'b1);

        // Test 1: one row, latency of row_valid after the last pixel
        row_ready = 1'b1;
        for (int k = 0; k < W; k++) begin
            send_px(DB'(k), 1'b0, 20, ok);
            if (!ok) check("t1_timeout", 0, 1);
            if (k == W - 2) check("t1_not_early", row_valid, 0);
        end
        check("t1_valid_n1", row_valid, 1);
        check("t1_byte0", row_data[7:0], 0);
        check("t1_byte23", row_data[191:184], 23);
        check("t1_idx", row_idx, 0);
        drain(50);

        // Test 2: full frame plus the first row of the next frame
        tb_reset(1'b0);
        row_ready = 1'b1;
        send_px(8'h11, 1'b1, 20, ok);
        if (!ok) check("t2_timeout", 0, 1);
        stream(W * H + W - 1, 5);
        drain(100);
        check("t2_rows", rows_out, W + 1);
        check("t2_frame_done_cnt", fd_cnt, 1);
        check("t2_wrap_idx", last_idx, 0);
        check("t2_sof_err", sof_err, 0);

        // Test 3: backpressure table with row_ready held low
        foreach (bp_tbl[t]) begin
            tb_reset(1'b0);
            row_ready = 1'b0;
            acc = 0;
            for (int i = 0; i < bp_tbl[t].n_px; i++) begin
                send_px(DB'(i), 1'b0, 4, ok);
                acc += int'(ok);
            end
            @(negedge clk);
            check($sformatf("bp%0d_accepted", t), acc, bp_tbl[t].exp_acc);
            check($sformatf("bp%0d_s_ready", t), s_ready, bp_tbl[t].exp_ready);
            check($sformatf("bp%0d_row_valid", t), row_valid, bp_tbl[t].exp_valid);
            if (bp_tbl[t].exp_valid) begin
                check($sformatf("bp%0d_row_data", t), row_data, row0);
                check($sformatf("bp%0d_row_idx", t), row_idx, 0);
            end
        end
        row_ready = 1'b1;
        drain(50);
        check("t3_rows_drained", rows_out, 2);
        check("t3_s_ready_back", s_ready, 1);
        check("t3_row_valid_low", row_valid, 0);

        // Test 4: s_sof on pixel 10 of row 3
        tb_reset(1'b0);
        row_ready = 1'b1;
        stream(3 * W + 10, 40);
        send_px(8'hA5, 1'b1, 20, ok);
        if (!ok) check("t4_timeout", 0, 1);
        stream(W - 1, 90);
        drain(50);
        check("t4_sof_err", sof_err, 1);
        check("t4_rows", rows_out, 4);
        check("t4_idx", last_idx, 0);
        check("t4_first_px", last_data[7:0], 8'hA5);

        // Test 5: reset in the middle of row 5, sof_err must clear
        stream(4 * W + 7, 3);
        drain(50);
        check("t5_pre_rows", rows_out, 8);
        tb_reset(1'b1);
        row_ready = 1'b1;
        stream(W, 77);
        drain(50);
        check("t5_rows", rows_out, 1);
        check("t5_idx", last_idx, 0);

        // Test 6: random valid/ready over three frames
        tb_reset(1'b0);
        rnd_en = 1'b1;
        for (int i = 0; i < 3 * W * H; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            send_px(DB'($urandom), (i % (W * H)) == 0, 400, ok);
            if (!ok) check("t6_timeout", 0, 1);
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #2 row_ready = 1'b1;
        drain(200);
        check("t6_accepted", acc_cnt, 3 * W * H);
        check("t6_rows", rows_out, 3 * H);
        check("t6_frame_done_cnt", fd_cnt, 3);
        check("t6_sof_err", sof_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
